// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: owns the fetch PC, keeps at most one req/gnt/rvalid
// transaction in flight, and feeds the IF/ID register through a one-entry skid buffer.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_err_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_address_o,
    output logic        valid_m_instruction_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
        logic        valid;
    } fetch_t;

    localparam fetch_t BUBBLE = '{insn: NOP_INSN, pc: 32'h0, valid: 1'b0};

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        kill_q, kill_d;
    logic        skid_full_q;
    fetch_t      skid_q;
    fetch_t      ifid_q;

    fetch_t      rsp;
    logic        rsp_ok;
    logic        rsp_take;
    logic        rsp_park;
    logic        skid_drain;

    // A response is usable only if it is not from a killed request and not
    // overtaken by a redirect in the very cycle it arrives.
    assign rsp_take   = (state_q == RESP) && imem_rvalid_i && !kill_q && !redirect_i;
    assign rsp_ok     = !imem_err_i && (pend_pc_q[1:0] == 2'b00);
    assign rsp        = '{insn: rsp_ok ? imem_rdata_i : NOP_INSN, pc: pend_pc_q, valid: rsp_ok};
    assign rsp_park   = rsp_take && !flush_i && (stall_i || skid_full_q);
    assign skid_drain = skid_full_q && (flush_i || !stall_i);

    assign imem_addr_o = {pc_q[31:2], 2'b00};

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        kill_d     = kill_q;
        imem_req_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!skid_full_q || skid_drain) state_d = REQ;
            end
            REQ: begin
                imem_req_o = 1'b1;
                if (imem_gnt_i) begin
                    pend_pc_d = pc_q;
                    pc_d      = pc_q + 32'd4;
                    kill_d    = redirect_i;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (imem_rvalid_i) begin
                    kill_d  = 1'b0;
                    state_d = rsp_park ? IDLE : REQ;
                end else if (redirect_i) begin
                    kill_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (redirect_i) pc_d = redirect_pc_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            pend_pc_q <= '0;
            kill_q    <= 1'b0;
        end else begin
            // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            kill_q    <= kill_d;
        end
    end

    // IF/ID register and skid buffer; flush outranks stall, which outranks draining.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ifid_q      <= BUBBLE;
            skid_q      <= BUBBLE;
            skid_full_q <= 1'b0;
        end else if (flush_i) begin
            ifid_q      <= BUBBLE;
            skid_full_q <= 1'b0;
        end else if (stall_i) begin
            if (rsp_take) begin
                skid_q      <= rsp;
                skid_full_q <= 1'b1;
            end
        end else if (skid_full_q) begin
            ifid_q      <= skid_q;
            skid_full_q <= rsp_take;
            if (rsp_take) skid_q <= rsp;
        end else if (rsp_take) begin
            ifid_q <= rsp;
        end else begin
            ifid_q <= BUBBLE;
        end
    end

    assign instruction_o         = ifid_q.insn;
    assign pc_address_o          = ifid_q.pc;
    assign valid_m_instruction_o = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a per-cycle vector table, hand-written corner sequences, and a
// randomized run against an in-order instruction-stream reference model.
module tb_if_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] SALT = 32'hA5A5_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        imem_err_i = 1'b0;
    logic [31:0] instruction_o;
    logic [31:0] pc_address_o;
    logic        valid_m_instruction_o;

    always #5 clk_i = ~clk_i;

    if_stage #(.RESET_PC(32'h0), .NOP_INSN(NOP)) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .stall_i               (stall_i),
        .flush_i               (flush_i),
        .redirect_i            (redirect_i),
        .redirect_pc_i         (redirect_pc_i),
        .imem_req_o            (imem_req_o),
        .imem_addr_o           (imem_addr_o),
        .imem_gnt_i            (imem_gnt_i),
        .imem_rvalid_i         (imem_rvalid_i),
        .imem_rdata_i          (imem_rdata_i),
        .imem_err_i            (imem_err_i),
        .instruction_o         (instruction_o),
        .pc_address_o          (pc_address_o),
        .valid_m_instruction_o (valid_m_instruction_o)
    );

    typedef struct {
        logic        stall, flush, redir;
        logic [31:0] rpc;
        logic        gnt, rvalid;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr, e_insn, e_pc;
        logic        e_v;
    } vec_t;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return a ^ SALT;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic er, input logic [31:0] ea,
                             input logic [31:0] ei, input logic [31:0] ep, input logic ev);
        check({name, ".req"}, {31'b0, imem_req_o}, {31'b0, er});
        if (er) check({name, ".addr"}, imem_addr_o, ea);
        check({name, ".insn"}, instruction_o, ei);
        check({name, ".pc"}, pc_address_o, ep);
        check({name, ".valid"}, {31'b0, valid_m_instruction_o}, {31'b0, ev});
    endtask

    task automatic set_in(input logic s, input logic f, input logic r, input logic [31:0] rpc,
                          input logic g, input logic v, input logic [31:0] rdat, input logic e);
        stall_i = s; flush_i = f; redirect_i = r; redirect_pc_i = rpc;
        imem_gnt_i = g; imem_rvalid_i = v; imem_rdata_i = rdat; imem_err_i = e;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    function automatic vec_t mk(input logic s, input logic f, input logic r, input logic [31:0] rpc,
                                input logic g, input logic v, input logic [31:0] rdat,
                                input logic er, input logic [31:0] ea, input logic [31:0] ei,
                                input logic [31:0] ep, input logic ev);
        vec_t t;
        t.stall = s; t.flush = f; t.redir = r; t.rpc = rpc;
        t.gnt = g; t.rvalid = v; t.rdata = rdat;
        t.e_req = er; t.e_addr = ea; t.e_insn = ei; t.e_pc = ep; t.e_v = ev;
        return t;
    endfunction

    vec_t tbl [19];

    // Random-phase reference state: memory model plus expected instruction stream.
    logic        m_pend;
    logic [31:0] m_addr;
    int          m_cnt;
    logic [31:0] exp_pc;
    int          delivered;

    initial begin
        // Outputs sampled at cycle start, then that cycle's inputs applied.
        tbl[0]  = mk(0,0,0,0,     0,0,0,          0,0,      NOP,       0,      0);
        tbl[1]  = mk(0,0,0,0,     1,0,0,          1,0,      NOP,       0,      0);
        tbl[2]  = mk(0,0,0,0,     0,1,rd(0),      0,0,      NOP,       0,      0);
        tbl[3]  = mk(0,0,0,0,     1,0,0,          1,4,      rd(0),     0,      1);
        tbl[4]  = mk(0,0,0,0,     0,1,rd(4),      0,0,      NOP,       0,      0);
        tbl[5]  = mk(1,0,0,0,     1,0,0,          1,8,      rd(4),     4,      1);
        tbl[6]  = mk(1,0,0,0,     0,0,0,          0,0,      rd(4),     4,      1);
        tbl[7]  = mk(1,0,0,0,     0,1,rd(8),      0,0,      rd(4),     4,      1);
        tbl[8]  = mk(1,0,0,0,     0,0,0,          0,0,      rd(4),     4,      1);
        tbl[9]  = mk(0,0,0,0,     0,0,0,          0,0,      rd(4),     4,      1);
        tbl[10] = mk(0,0,0,0,     1,0,0,          1,32'hC,  rd(8),     8,      1);
        tbl[11] = mk(0,0,0,0,     0,1,rd(32'hC),  0,0,      NOP,       0,      0);
        tbl[12] = mk(0,0,0,0,     1,0,0,          1,32'h10, rd(32'hC), 32'hC,  1);
        tbl[13] = mk(0,1,1,32'h100,0,0,0,         0,0,      NOP,       0,      0);
        tbl[14] = mk(0,0,0,0,     0,1,rd(32'h10), 0,0,      NOP,       0,      0);
        tbl[15] = mk(0,0,0,0,     1,0,0,          1,32'h100,NOP,       0,      0);
        tbl[16] = mk(0,0,0,0,     0,1,rd(32'h100),0,0,      NOP,       0,      0);
        tbl[17] = mk(0,0,0,0,     0,0,0,          1,32'h104,rd(32'h100),32'h100,1);
        tbl[18] = mk(0,0,0,0,     0,0,0,          1,32'h104,NOP,       0,      0);

        do_reset();
        for (int i = 0; i < 19; i++) begin
            check_out($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr,
                      tbl[i].e_insn, tbl[i].e_pc, tbl[i].e_v);
            set_in(tbl[i].stall, tbl[i].flush, tbl[i].redir, tbl[i].rpc,
                   tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata, 1'b0);
            step();
        end

        // Redirect while REQ waits without gnt: only the target is fetched.
        set_in(0, 1, 1, 32'h200, 0, 0, 0, 0); step();
        check_out("redir_req_a", 1, 32'h200, NOP, 0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0); step();
        check_out("redir_req_b", 1, 32'h200, NOP, 0, 0);
        set_in(0, 0, 0, 0, 1, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 1, rd(32'h200), 0); step();
        check_out("redir_req_c", 1, 32'h204, rd(32'h200), 32'h200, 1);

        // Bus error at 0x8.
        set_in(0, 1, 1, 32'h8, 0, 0, 0, 0); step();
        check_out("err_a", 1, 32'h8, NOP, 0, 0);
        set_in(0, 0, 0, 0, 1, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 1, rd(32'h8), 1); step();
        check_out("err_b", 1, 32'hC, NOP, 32'h8, 0);

        // Misaligned redirect target.
        set_in(0, 1, 1, 32'h102, 0, 0, 0, 0); step();
        check_out("misal_a", 1, 32'h100, NOP, 0, 0);
        set_in(0, 0, 0, 0, 1, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 1, rd(32'h100), 0); step();
        check_out("misal_b", 1, 32'h104, NOP, 32'h102, 0);

        // PC wrap from the top of the address space.
        set_in(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0); step();
        check_out("wrap_a", 1, 32'hFFFF_FFFC, NOP, 0, 0);
        set_in(0, 0, 0, 0, 1, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 1, rd(32'hFFFF_FFFC), 0); step();
        check_out("wrap_b", 1, 32'h0, rd(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1);
        set_in(1, 0, 0, 0, 1, 0, 0, 0); step();
        check_out("wrap_c", 0, 0, rd(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1);

        // Asynchronous reset in the middle of RESP, between clock edges.
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_ni = 1'b0;
        #1;
        check_out("async_rst", 0, 0, NOP, 0, 0);
        check("async_rst.addr", imem_addr_o, 32'h0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        check_out("post_rst_a", 0, 0, NOP, 0, 0);
        step();
        check_out("post_rst_b", 1, 32'h0, NOP, 0, 0);

        // Randomized run: delivered instructions must form the in-order stream
        // exp_pc, exp_pc+4, ... restarting at each redirect target.
        do_reset();
        m_pend = 1'b0; m_addr = '0; m_cnt = 0;
        exp_pc = 32'h0; delivered = 0;
        begin
            logic        p_stall, p_flush, p_req, p_gnt, p_redir, rv, g;
            logic [31:0] p_addr, h_insn, h_pc, tmp;
            logic        h_v;
            p_stall = 0; p_flush = 0; p_req = 0; p_gnt = 0; p_redir = 0; p_addr = '0;
            h_insn = instruction_o; h_pc = pc_address_o; h_v = valid_m_instruction_o;
            for (int c = 0; c < 4000; c++) begin
                if (!p_flush && p_stall) begin
                    check("rnd.hold_insn", instruction_o, h_insn);
                    check("rnd.hold_pc", pc_address_o, h_pc);
                    check("rnd.hold_v", {31'b0, valid_m_instruction_o}, {31'b0, h_v});
                end else if (!p_flush && valid_m_instruction_o) begin
                    check("rnd.pc", pc_address_o, exp_pc);
                    check("rnd.insn", instruction_o, rd(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    delivered++;
                end
                h_insn = instruction_o; h_pc = pc_address_o; h_v = valid_m_instruction_o;
                if (p_req && !p_gnt && !p_redir && imem_req_o)
                    check("rnd.addr_stable", imem_addr_o, p_addr);
                if (imem_req_o)
                    check("rnd.one_outstanding", {31'b0, m_pend}, 32'h0);

                stall_i    = (c < 3500) && ($urandom % 4 == 0);
                redirect_i = (c < 3500) && ($urandom % 32 == 0);
                flush_i    = redirect_i;
                tmp = $urandom_range(0, 1023);
                redirect_pc_i = tmp << 2;
                if (redirect_i) exp_pc = redirect_pc_i;
                rv = m_pend && (m_cnt == 0);
                imem_rvalid_i = rv;
                imem_rdata_i  = rv ? rd(m_addr) : $urandom;
                imem_err_i    = 1'b0;
                g = imem_req_o && ($urandom % 3 != 0);
                imem_gnt_i = g;
                p_stall = stall_i; p_flush = flush_i; p_redir = redirect_i;
                p_req = imem_req_o; p_gnt = g; p_addr = imem_addr_o;
                step();
                if (rv) m_pend = 1'b0;
                if (p_req && g) begin
                    m_pend = 1'b1;
                    m_addr = p_addr;
                    m_cnt  = $urandom % 3;
                end else if (m_pend && !rv) begin
                    m_cnt--;
                end
            end
        end
        check("rnd.liveness", {31'b0, delivered >= 150}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
